// File: rtl/ising_run_ctrl.sv
// Run controller for the Ising array: drives reset/settle/sample runs per job,
// scores each stable sample as a max-cut value and keeps the best normalized phase.
module ising_run_ctrl #(
   parameter int N              = 6,
   parameter int NUM_WEIGHTS    = 3,
   parameter int WEIGHT_W       = $clog2(NUM_WEIGHTS),
   parameter int NUM_PAIRS      = N*(N-1)/2,
   parameter int WB             = NUM_PAIRS*WEIGHT_W,
   parameter int CUT_W          = $clog2(NUM_PAIRS+1),
   parameter int SETTLE_W       = 16,
   parameter int RUNS_W         = 4,
   parameter int STABLE_CYCLES  = 8,
   parameter int SAMPLE_TIMEOUT = 128
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [WB-1:0]       weights_in,
   input  logic [SETTLE_W-1:0] settle_cycles,
   input  logic [RUNS_W-1:0]   num_runs,
   input  logic [N-1:0]        phase_in,
   output logic                array_rstn,
   output logic [WB-1:0]       array_weights,
   output logic                busy,
   output logic                done,
   output logic [N-1:0]        best_phase,
   output logic [CUT_W-1:0]    best_cut,
   output logic                best_valid,
   output logic [RUNS_W-1:0]   runs_done,
   output logic [RUNS_W-1:0]   unstable_runs
);

   localparam int SW = $clog2(STABLE_CYCLES+1);
   localparam int TW = $clog2(SAMPLE_TIMEOUT);
   localparam int PW = $clog2(NUM_PAIRS);
   localparam int IW = $clog2(N);

   typedef enum logic [2:0] {IDLE, ARST, SETTLE, SAMPLE, SCORE, UPDATE, DONE_S} state_t;

   state_t              state;
   logic [SETTLE_W-1:0] settle_q;
   logic [SETTLE_W-1:0] set_cnt;
   logic [RUNS_W-1:0]   runs_q;
   logic [RUNS_W:0]     arst_cnt;
   logic [RUNS_W:0]     arst_last;
   logic [N-1:0]        sample_q;
   logic [SW-1:0]       stab_cnt;
   logic [SW-1:0]       stab_next;
   logic [TW-1:0]       tmo_cnt;
   logic [N-1:0]        cur_phase;
   logic                run_ok;
   logic [PW-1:0]       pair_cnt;
   logic [IW-1:0]       pi;
   logic [IW-1:0]       pj;
   logic [CUT_W-1:0]    cut_acc;
   logic [WEIGHT_W-1:0] w_sel;
   logic                pair_hit;

   // Run r holds the array in reset for 4+r cycles so each run starts from a different phase.
   assign arst_last = {1'b0, runs_done} + (RUNS_W+1)'(3);

   always_comb begin
      stab_next = SW'(1);
      if (stab_cnt != '0 && phase_in == sample_q)
         stab_next = stab_cnt + SW'(1);
      w_sel    = array_weights[WEIGHT_W*int'(pair_cnt) +: WEIGHT_W];
      pair_hit = (w_sel == '0) && (cur_phase[pi] != cur_phase[pj]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         array_rstn    <= 1'b0;
         array_weights <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         best_phase    <= '0;
         best_cut      <= '0;
         best_valid    <= 1'b0;
         runs_done     <= '0;
         unstable_runs <= '0;
         settle_q      <= '0;
         set_cnt       <= '0;
         runs_q        <= '0;
         arst_cnt      <= '0;
         sample_q      <= '0;
         stab_cnt      <= '0;
         tmo_cnt       <= '0;
         cur_phase     <= '0;
         run_ok        <= 1'b0;
         pair_cnt      <= '0;
         pi            <= '0;
         pj            <= '0;
         cut_acc       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               array_rstn <= 1'b0;
               if (start) begin
                  array_weights <= weights_in;
                  settle_q      <= settle_cycles;
                  runs_q        <= (num_runs == '0) ? RUNS_W'(1) : num_runs;
                  best_phase    <= '0;
                  best_cut      <= '0;
                  best_valid    <= 1'b0;
                  runs_done     <= '0;
                  unstable_runs <= '0;
                  busy          <= 1'b1;
                  arst_cnt      <= '0;
                  state         <= ARST;
               end
            end
            ARST: begin
               if (arst_cnt == arst_last) begin
                  array_rstn <= 1'b1;
                  set_cnt    <= '0;
                  stab_cnt   <= '0;
                  tmo_cnt    <= '0;
                  state      <= (settle_q == '0) ? SAMPLE : SETTLE;
               end else begin
                  arst_cnt <= arst_cnt + 1'b1;
               end
            end
            SETTLE: begin
               if (set_cnt == settle_q - 1'b1) state <= SAMPLE;
               else                            set_cnt <= set_cnt + 1'b1;
            end
            SAMPLE: begin
               sample_q <= phase_in;
               stab_cnt <= stab_next;
               tmo_cnt  <= tmo_cnt + 1'b1;
               if (stab_next == SW'(STABLE_CYCLES)) begin
                  // Normalize so the local-field spin is always 1; the cut is symmetric.
                  cur_phase <= phase_in[N-1] ? phase_in : ~phase_in;
                  run_ok    <= 1'b1;
                  pair_cnt  <= '0;
                  pi        <= '0;
                  pj        <= IW'(1);
                  cut_acc   <= '0;
                  state     <= SCORE;
               end else if (tmo_cnt == TW'(SAMPLE_TIMEOUT-1)) begin
                  run_ok        <= 1'b0;
                  unstable_runs <= unstable_runs + 1'b1;
                  state         <= UPDATE;
               end
            end
            SCORE: begin
               cut_acc  <= cut_acc + CUT_W'(pair_hit);
               pair_cnt <= pair_cnt + 1'b1;
               if (pj == IW'(N-1)) begin
                  pi <= pi + 1'b1;
                  pj <= pi + IW'(2);
               end else begin
                  pj <= pj + 1'b1;
               end
               if (pair_cnt == PW'(NUM_PAIRS-1)) state <= UPDATE;
            end
            UPDATE: begin
               if (run_ok && (!best_valid || cut_acc > best_cut)) begin
                  best_phase <= cur_phase;
                  best_cut   <= cut_acc;
                  best_valid <= 1'b1;
               end
               runs_done  <= runs_done + 1'b1;
               array_rstn <= 1'b0;
               arst_cnt   <= '0;
               if (runs_done + 1'b1 == runs_q) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= DONE_S;
               end else begin
                  state <= ARST;
               end
            end
            DONE_S: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ising_run_ctrl.sv
// Randomized and directed jobs for ising_run_ctrl; a reference model predicts each
// job's results and done time, and a monitor checks them when done pulses.
module tb_ising_run_ctrl;

   localparam int EW = 51;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [29:0] weights_in = '0;
   logic [15:0] settle_cycles = '0;
   logic [3:0]  num_runs = '0;
   logic [5:0]  phase_in = '0;
   logic        array_rstn;
   logic [29:0] array_weights;
   logic        busy;
   logic        done;
   logic [5:0]  best_phase;
   logic [3:0]  best_cut;
   logic        best_valid;
   logic [3:0]  runs_done;
   logic [3:0]  unstable_runs;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   logic [EW-1:0] exp_q[$];

   bit         run_stable[17];
   logic [5:0] run_phase[17];
   logic [5:0] run_alt[17];
   int         job_id = 0;

   ising_run_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .weights_in(weights_in),
      .settle_cycles(settle_cycles), .num_runs(num_runs), .phase_in(phase_in),
      .array_rstn(array_rstn), .array_weights(array_weights), .busy(busy), .done(done),
      .best_phase(best_phase), .best_cut(best_cut), .best_valid(best_valid),
      .runs_done(runs_done), .unstable_runs(unstable_runs)
   );

   // clock / cycle count
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // reference model: max cut of a phase with A at bit 0, pairs row-major from the LSB
   function automatic int cut_of(logic [29:0] w, logic [5:0] ph);
      int p = 0;
      int c = 0;
      for (int i = 0; i < 6; i++)
         for (int j = i + 1; j < 6; j++) begin
            if (w[2*p +: 2] == 2'b00 && ph[i] != ph[j]) c++;
            p++;
         end
      return c;
   endfunction

   function automatic logic [EW-1:0] model_job(logic [29:0] w, int s, int n, int c0);
      int nr = (n == 0) ? 1 : n;
      int total = 0;
      int bc = 0;
      int unst = 0;
      bit bv = 0;
      logic [5:0] bp = '0;
      logic [5:0] norm;
      int c;
      logic [31:0] done_at;
      for (int r = 0; r < nr; r++) begin
         if (run_stable[r]) begin
            total += 4 + r + s + 8 + 15 + 1;
            norm = run_phase[r][5] ? run_phase[r] : ~run_phase[r];
            c = cut_of(w, norm);
            if (!bv || c > bc) begin
               bv = 1;
               bc = c;
               bp = norm;
            end
         end else begin
            total += 4 + r + s + 128 + 1;
            unst++;
         end
      end
      done_at = 32'(c0 + 1 + total);
      return {done_at, bp, 4'(bc), bv, 4'(nr), 4'(unst)};
   endfunction

   // phase stimulus: one pattern per run, advanced when the array re-enters reset
   int  seen_job = 0;
   int  run_ptr = 0;
   int  tog_cnt = 0;
   logic prev_rstn = 1'b0;
   always @(negedge clk) begin
      if (job_id != seen_job) begin
         seen_job = job_id;
         run_ptr = 0;
      end else if (prev_rstn && !array_rstn && run_ptr < 16) begin
         run_ptr++;
      end
      prev_rstn = array_rstn;
      tog_cnt++;
      if (run_stable[run_ptr]) phase_in = run_phase[run_ptr];
      else phase_in = ((tog_cnt / 3) % 2 == 1) ? run_alt[run_ptr] : run_phase[run_ptr];
   end

   // monitor / scoreboard
   logic prev_done = 1'b0;
   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (!rst) begin
         if (prev_done) chk("done_one_cycle", 32'(done), 32'd0);
         if (done) begin
            chk("done_expected", 32'(exp_q.size() != 0), 32'd1);
            chk("busy_low_at_done", 32'(busy), 32'd0);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("done_cycle", 32'(cyc), e[50:19]);
               chk("best_phase", 32'(best_phase), 32'(e[18:13]));
               chk("best_cut", 32'(best_cut), 32'(e[12:9]));
               chk("best_valid", 32'(best_valid), 32'(e[8]));
               chk("runs_done", 32'(runs_done), 32'(e[7:4]));
               chk("unstable_runs", 32'(unstable_runs), 32'(e[3:0]));
            end
         end
      end
      prev_done = done;
   end

   function automatic logic [29:0] pentagon();
      logic [29:0] w = '0;
      int p = 0;
      for (int i = 0; i < 6; i++)
         for (int j = i + 1; j < 6; j++) begin
            if (j == 5) w[2*p +: 2] = 2'b10;
            else if ((i == 0 && (j == 1 || j == 4)) || (i == 1 && (j == 2 || j == 3)) ||
                     (i == 2 && j == 3) || (i == 3 && j == 4)) w[2*p +: 2] = 2'b00;
            else w[2*p +: 2] = 2'b01;
            p++;
         end
      return w;
   endfunction

   task automatic issue_start(input logic [29:0] w, input int s, input int n);
      job_id++;
      repeat (2) @(negedge clk);
      weights_in = w;
      settle_cycles = 16'(s);
      num_runs = 4'(n);
      start = 1'b1;
      exp_q.push_back(model_job(w, s, n, cyc));
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      chk("rstn_after_start", 32'(array_rstn), 32'd0);
   endtask

   task automatic run_job(input logic [29:0] w, input int s, input int n,
                          input bit extra_start, input bit start_at_done);
      int budget;
      issue_start(w, s, n);
      if (extra_start) begin
         repeat ($urandom_range(3, 20)) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      budget = 3000;
      while (!done && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) begin
         chk("done_timeout", 32'd0, 32'd1);
         exp_q.delete();
      end else if (start_at_done) begin
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         chk("start_at_done_ignored", 32'(busy), 32'd0);
      end
      @(negedge clk);
   endtask

   task automatic set_runs(input int n, input bit stable, input logic [5:0] ph);
      for (int r = 0; r < 17; r++) begin
         run_stable[r] = stable;
         run_phase[r] = ph;
         run_alt[r] = ~ph;
      end
   endtask

   initial begin
      logic [29:0] w;
      int n;
      set_runs(17, 1'b1, 6'b101101);
      repeat (3) @(negedge clk);
      chk("reset_rstn", 32'(array_rstn), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_best_valid", 32'(best_valid), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // single stable run, then its inverted image
      set_runs(17, 1'b1, 6'b101101);
      run_job(pentagon(), 20, 1, 1'b0, 1'b1);
      set_runs(17, 1'b1, 6'b010010);
      run_job(pentagon(), 20, 1, 1'b0, 1'b0);

      // three runs with a tie on the best cut
      set_runs(17, 1'b1, 6'b100000);
      run_phase[1] = 6'b101101;
      run_phase[2] = 6'b110010;
      run_job(pentagon(), 4, 3, 1'b0, 1'b0);

      // never-stable input
      set_runs(17, 1'b0, 6'b010101);
      run_job(pentagon(), 10, 1, 1'b0, 1'b0);

      // zero counts
      set_runs(17, 1'b1, 6'b110010);
      run_job(pentagon(), 0, 0, 1'b0, 1'b0);

      // reset during SETTLE
      set_runs(17, 1'b1, 6'b101101);
      job_id++;
      repeat (2) @(negedge clk);
      weights_in = pentagon();
      settle_cycles = 16'd20;
      num_runs = 4'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_rstn", 32'(array_rstn), 32'd0);
      chk("midrst_weights", 32'(array_weights), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_best_phase", 32'(best_phase), 32'd0);
      chk("midrst_best_cut", 32'(best_cut), 32'd0);
      chk("midrst_best_valid", 32'(best_valid), 32'd0);
      chk("midrst_runs_done", 32'(runs_done), 32'd0);
      chk("midrst_unstable", 32'(unstable_runs), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // start pulse while busy must be ignored
      run_job(pentagon(), 6, 2, 1'b1, 1'b0);

      // randomized jobs
      for (int k = 0; k < 10; k++) begin
         w = 30'($urandom);
         n = $urandom_range(0, 3);
         for (int r = 0; r < 17; r++) begin
            run_stable[r] = ($urandom_range(0, 3) != 0);
            run_phase[r] = 6'($urandom);
            run_alt[r] = run_phase[r] ^ 6'($urandom_range(1, 63));
         end
         run_job(w, $urandom_range(0, 6), n, ($urandom_range(0, 2) == 0), 1'b0);
      end

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
